polar_cw_serializer: RTL



---
 rtl/polar_ser_pkg.sv | 17 +
 rtl/polar_cw_buf.sv | 54 +++++
 rtl/polar_cw_serializer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/polar_ser_pkg.sv
// polar_ser_pkg: shared constants and the occupancy state encoding for the
// polar codeword serializer.
package polar_ser_pkg;

  localparam int CW_LEN = 1024;              // codeword length in bits
  localparam int OUT_W  = 32;                // output word width in bits
  localparam int WORDS  = CW_LEN / OUT_W;    // words per codeword
  localparam int IDX_W  = $clog2(WORDS);     // word index width

  // Number of occupied ping-pong entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } occ_state_t;

endpackage

// File: rtl/polar_cw_buf.sv
// polar_cw_buf: one ping-pong entry of the serializer. Holds a full codeword,
// its rate tag and an occupancy flag, and selects one OUT_W-bit word of the
// codeword by index (word 0 = least significant bits).
module polar_cw_buf
  import polar_ser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [CW_LEN-1:0] i_wr_data,
  input  logic              i_wr_rate,
  input  logic              i_free,
  input  logic [IDX_W-1:0]  i_idx,
  output logic              o_full,
  output logic              o_rate,
  output logic [OUT_W-1:0]  o_word
);

  logic [CW_LEN-1:0] r_data;
  logic              r_rate;
  logic              r_full;
  logic [OUT_W-1:0]  w_words [WORDS];

  // Codeword payload: only meaningful while r_full is set, so no reset needed.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_data <= i_wr_data;
    end
  end

  // Occupancy and rate tag; a write wins over a same-cycle free so that the
  // entry being drained can be refilled on its last-word handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= 1'b0;
      r_rate <= 1'b0;
    end else if (i_wr_en) begin
      r_full <= 1'b1;
      r_rate <= i_wr_rate;
    end else if (i_free) begin
      r_full <= 1'b0;
    end
  end

  // Split the codeword into its output words, LSB word first.
  for (genvar gi = 0; gi < WORDS; gi++) begin : g_word
    assign w_words[gi] = r_data[gi*OUT_W +: OUT_W];
  end

  assign o_word = w_words[i_idx];
  assign o_full = r_full;
  assign o_rate = r_rate;

endmodule

// File: rtl/polar_cw_serializer.sv
// polar_cw_serializer: captures polar encoder codewords into a two-entry
// ping-pong buffer and streams them out as OUT_W-bit words over valid/ready,
// tagging each word with sop/last/rate and flagging dropped codewords.
// Optional macro POLAR_SER_CNT_EN adds completed/dropped codeword counters.
module polar_cw_serializer
  import polar_ser_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              polar_enc_done,
  input  logic [CW_LEN-1:0] polar_enc_data_dout,
  input  logic              polar_rate_sel,
  input  logic              ser_ovf_clr,
  input  logic              ser_ready,
  output logic              ser_valid,
  output logic [OUT_W-1:0]  ser_data,
  output logic              ser_sop,
  output logic              ser_last,
  output logic              ser_rate,
  output logic              ser_busy,
  output logic              ser_overflow
`ifdef POLAR_SER_CNT_EN
  ,
  output logic [15:0]       ser_cw_cnt,
  output logic [7:0]        ser_drop_cnt
`endif
);

  occ_state_t       r_state;
  occ_state_t       w_state_next;
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [IDX_W-1:0] r_idx;
  logic             r_ovf;

  logic             w_capture;
  logic             w_drop;
  logic             w_valid;
  logic             w_xfer;
  logic             w_last_xfer;
  logic             w_is_last;
  logic [1:0]       w_wr_en;
  logic [1:0]       w_free;
  logic [1:0]       w_full;
  logic [1:0]       w_rate;
  logic [OUT_W-1:0] w_word [2];

  // Two ping-pong entries; writes go to wr_ptr, reads come from rd_ptr.
  for (genvar gi = 0; gi < 2; gi++) begin : g_buf
    assign w_wr_en[gi] = w_capture & (r_wr_ptr == 1'(gi));
    assign w_free[gi]  = w_last_xfer & (r_rd_ptr == 1'(gi));

    polar_cw_buf u_buf (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_wr_en   (w_wr_en[gi]),
      .i_wr_data (polar_enc_data_dout),
      .i_wr_rate (polar_rate_sel),
      .i_free    (w_free[gi]),
      .i_idx     (r_idx),
      .o_full    (w_full[gi]),
      .o_rate    (w_rate[gi]),
      .o_word    (w_word[gi])
    );
  end

  assign w_valid     = w_full[r_rd_ptr];
  assign w_is_last   = (r_idx == IDX_W'(WORDS - 1));
  assign w_xfer      = w_valid & ser_ready;
  assign w_last_xfer = w_xfer & w_is_last;

  // Output stream, gated to zero whenever no word is being presented.
  assign ser_valid    = w_valid;
  assign ser_data     = w_valid ? w_word[r_rd_ptr] : '0;
  assign ser_sop      = w_valid & (r_idx == '0);
  assign ser_last     = w_valid & w_is_last;
  assign ser_rate     = w_valid & w_rate[r_rd_ptr];
  assign ser_busy     = |w_full;
  assign ser_overflow = r_ovf;

  // Occupancy next-state: decide capture vs. drop for an incoming codeword.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    w_drop       = 1'b0;
    case (r_state)
      EMPTY: begin
        if (polar_enc_done) begin
          w_capture    = 1'b1;
          w_state_next = ONE;
        end
      end
      ONE: begin
        if (polar_enc_done && w_last_xfer) begin
          w_capture    = 1'b1;
        end else if (polar_enc_done) begin
          w_capture    = 1'b1;
          w_state_next = TWO;
        end else if (w_last_xfer) begin
          w_state_next = EMPTY;
        end
      end
      TWO: begin
        if (polar_enc_done && w_last_xfer) begin
          w_capture    = 1'b1;
        end else if (polar_enc_done) begin
          w_drop       = 1'b1;
        end else if (w_last_xfer) begin
          w_state_next = ONE;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  // State, pointers, word index and sticky overflow (a new drop beats clear).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= EMPTY;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_idx    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_capture) begin
        r_wr_ptr <= ~r_wr_ptr;
      end
      if (w_last_xfer) begin
        r_rd_ptr <= ~r_rd_ptr;
        r_idx    <= '0;
      end else if (w_xfer) begin
        r_idx    <= r_idx + IDX_W'(1);
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (ser_ovf_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

`ifdef POLAR_SER_CNT_EN
  logic [15:0] r_cw_cnt;
  logic [7:0]  r_drop_cnt;

  // Completed codewords wrap; dropped codewords saturate and clear with the flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cw_cnt   <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_last_xfer) begin
        r_cw_cnt <= r_cw_cnt + 16'd1;
      end
      if (w_drop) begin
        if (ser_ovf_clr) begin
          r_drop_cnt <= 8'd1;
        end else if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end else if (ser_ovf_clr) begin
        r_drop_cnt <= '0;
      end
    end
  end

  assign ser_cw_cnt   = r_cw_cnt;
  assign ser_drop_cnt = r_drop_cnt;
`endif

endmodule
